ram_scan_reader: RTL
====================

Name: ram_scan_reader

Overview:
- Read-side companion to the 16x4 switch-written RAM.
- On command, walks every RAM address in ascending order and drives the RAM read address.
- Captures each read word into display registers that feed the seven-segment decoder and address LEDs.
- Holds each captured word for a programmable dwell time, so a human can read the RAM contents back after writing them.

Parameters:
- ADDR_W, 4, RAM address width; scan covers 0 .. 2^ADDR_W-1.
- DATA_W, 4, RAM data width.
- DWELL, 4, dwell cycles per location; legal range 1 .. 2^CNT_W-1; board build uses 25000000.
- CNT_W, 32, width of the dwell counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle scan request; sampled only in IDLE.
- stop  input  1  abort request; sampled in every state.
- adr  output  ADDR_W  RAM read address.
- rdata  input  DATA_W  RAM read data; combinational (asynchronous) read of adr.
- disp_adr  output  ADDR_W  registered address of the last captured word.
- disp_data  output  DATA_W  registered last captured word.
- valid  output  1  one-cycle pulse, asserted the cycle after disp_* update.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when the scan completes.

Behaviour:
- States: IDLE, SETTLE, DWELL.
- Reset values: adr=0, disp_adr=0, disp_data=0, valid=0, busy=0, done=0, dwell counter=0, state=IDLE.
- Priority order: rst > stop > normal operation.
- IDLE:
  - start=1 and stop=0 → adr<=0, busy<=1, go SETTLE.
  - start=1 and stop=1 in the same cycle → remain IDLE, no outputs change.
- SETTLE (exactly 1 cycle; gives the async RAM a full cycle to settle on adr):
  - At the closing edge: disp_adr<=adr, disp_data<=rdata, valid<=1, cnt<=0, go DWELL.
- DWELL:
  - valid<=0; cnt increments each cycle.
  - When cnt==DWELL-1 and adr != 2^ADDR_W-1: adr<=adr+1, go SETTLE.
  - When cnt==DWELL-1 and adr == 2^ADDR_W-1 (last address): done<=1, busy<=0, go IDLE.
- Timing:
  - Each location occupies 1+DWELL cycles.
  - A full scan is 2^ADDR_W*(1+DWELL) cycles from the first SETTLE cycle to done.
  - valid and done are each high for exactly one cycle.
- start while busy: ignored; no restart, no effect on adr or cnt.
- stop in SETTLE or DWELL: next cycle state=IDLE, busy=0, valid=0, done stays 0; adr, disp_adr and disp_data hold their values.
- stop in IDLE: no effect.
- Address arithmetic is unsigned, ADDR_W bits; no address outside 0 .. 2^ADDR_W-1 is ever driven.
- The dwell counter is full CNT_W width; comparison against DWELL-1 is unsigned.
- rst mid-scan: all registers return to reset values on that edge; valid/done are not emitted.
- The block never writes the RAM and has no write-enable output.

Optional Feature:
- Macro: RAM_SCAN_LOOP_EN.
- Defined (continuous mode):
  - At the end of the last address's dwell: done<=1 for one cycle (wrap marker), adr<=0, go SETTLE, busy stays 1.
  - The scan repeats until stop or rst.
- Undefined: single-pass behaviour as described above; done ends the scan and busy falls in the same cycle done rises.

Test Plan:
1. Single pass, DWELL=4, RAM preloaded mem[i]=15-i; start pulse in cycle 0 → valid pulses in cycles 2, 7, 12 … 77 (every 5 cycles) carrying disp_adr=i, disp_data=15-i; done=1 and busy=0 in cycle 81; adr holds 15 afterwards.
2. Reset behaviour: assert rst in cycle 30 of test 1 → cycle 31 shows adr=0, disp_adr=0, disp_data=0, busy=0, no valid or done; a fresh start then reproduces test 1's timing exactly.
3. Start while busy: start pulses at cycles 0, 10 and 40 → cycle-identical trace to test 1, no restart, no extra valid pulse.
4. Abort: stop at cycle 13 (DWELL of adr 2) → cycle 14 busy=0, adr=2, disp_data=13, done never asserts; start+stop together in IDLE → no state change.
5. Edge dwell, DWELL=1, mem[i]=i → valid every 2 cycles, 16 captures, done in cycle 33; capture matches rdata for all addresses, including the wrap-free final address 15.
6. RAM_SCAN_LOOP_EN defined, DWELL=4 → done pulses in cycles 81 and 161, busy stays 1, adr returns to 0 in cycle 81; stop at cycle 100 → busy=0 in cycle 101.

Source files
------------

// File: rtl/ram_scan_reader_if.sv
// Bus between the RAM scan reader and the RAM / display side.
// master: the scan reader; slave: the command, RAM and display logic around it.
interface ram_scan_reader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] disp_adr;
    logic [DATA_W-1:0] disp_data;
    logic              valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, stop, rdata,
        output adr, disp_adr, disp_data, valid, busy, done
    );

    modport slave (
        output start, stop, rdata,
        input  adr, disp_adr, disp_data, valid, busy, done
    );
endinterface

// File: rtl/ram_scan_reader.sv
// Walks every RAM address, captures each word into display registers and holds it for DWELL cycles.
// Define RAM_SCAN_LOOP_EN to repeat the scan continuously until stop or rst.
module ram_scan_reader #(
    parameter int          ADDR_W = 4,
    parameter int          DATA_W = 4,
    parameter int          CNT_W  = 32,
    parameter int unsigned DWELL  = 4
) (
    input  logic              clk,
    input  logic              rst,
    ram_scan_reader_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DWELL} state_t;

    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] ADR_LAST   = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [ADDR_W-1:0] disp_adr_q, disp_adr_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dwell_end;

    assign dwell_end = (cnt_q == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            disp_adr_q  <= '0;
            disp_data_q <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            disp_adr_q  <= disp_adr_d;
            disp_data_q <= disp_data_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = bus.stop ? S_IDLE : S_DWELL;
            end
            S_DWELL: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (dwell_end) begin
                    if (adr_q != ADR_LAST) begin
                        state_d = S_SETTLE;
                    end else begin
`ifdef RAM_SCAN_LOOP_EN
                        state_d = S_SETTLE;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Abort holds adr and display registers; valid/done are single-cycle by default.
    always_comb begin
        adr_d       = adr_q;
        disp_adr_d  = disp_adr_q;
        disp_data_d = disp_data_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    adr_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (bus.stop) begin
                    busy_d = 1'b0;
                end else begin
                    disp_adr_d  = adr_q;
                    disp_data_d = bus.rdata;
                    valid_d     = 1'b1;
                    cnt_d       = '0;
                end
            end
            S_DWELL: begin
                if (bus.stop) begin
                    busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (dwell_end) begin
                        if (adr_q != ADR_LAST) begin
                            adr_d = adr_q + 1'b1;
                        end else begin
                            done_d = 1'b1;
`ifdef RAM_SCAN_LOOP_EN
                            adr_d  = '0;
`else
                            busy_d = 1'b0;
`endif
                        end
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.adr       = adr_q;
    assign bus.disp_adr  = disp_adr_q;
    assign bus.disp_data = disp_data_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
